// File: rtl/token_round_scheduler.sv
// Round-robin one-hot token issuer for the readout network: programmable slack
// interval, per-channel enable mask, grant timeout reporting and burst sweeps.
module token_round_scheduler #(
    parameter int NUM_CH  = 17,
    parameter int CH_W    = 5,
    parameter int SLACK_W = 33,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable_i,
    input  logic               burst_i,
    input  logic [SLACK_W-1:0] slack_cfg_i,
    input  logic [TMO_W-1:0]   timeout_cfg_i,
    input  logic [NUM_CH-1:0]  ch_mask_i,
    input  logic [NUM_CH-1:0]  TokenReady_i,
    output logic [NUM_CH-1:0]  TokenValid_o,
    output logic [CH_W-1:0]    cur_ch_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic [CH_W-1:0]    timeout_ch_o,
    output logic               round_done_o
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [SLACK_W-1:0] slack_q, slack_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic               timeout_q, timeout_d;
    logic [CH_W-1:0]    timeout_ch_q, timeout_ch_d;
    logic               round_done_q, round_done_d;

    logic [NUM_CH-1:0]  grant_vec;
    logic [CH_W-1:0]    nxt_ch;
    logic               nxt_wrap;
    logic [CH_W-1:0]    wrap_ch;
    logic               wrap_hit;
    logic [CH_W-1:0]    burst_ch;
    logic               burst_hit;
    logic               ready_hit;
    logic               tmo_hit;
    logic               done;

    assign nxt_wrap = (ptr_q == CH_W'(NUM_CH - 1));
    assign nxt_ch   = nxt_wrap ? '0 : ptr_q + CH_W'(1);

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_vec[i] = (state_q == ST_GRANT) && (ptr_q == CH_W'(i));
        end
    end

    // Wrapping search from ptr: upper segment [ptr, NUM_CH-1] first, then [0, ptr).
    // The burst search only looks at [nxt, NUM_CH-1] and never crosses the wrap.
    always_comb begin
        wrap_ch   = ptr_q;
        wrap_hit  = 1'b0;
        burst_ch  = '0;
        burst_hit = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!wrap_hit && ch_mask_i[j] && (CH_W'(j) >= ptr_q)) begin
                wrap_ch  = CH_W'(j);
                wrap_hit = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!wrap_hit && ch_mask_i[j]) begin
                wrap_ch  = CH_W'(j);
                wrap_hit = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!burst_hit && !nxt_wrap && ch_mask_i[j] && (CH_W'(j) >= nxt_ch)) begin
                burst_ch  = CH_W'(j);
                burst_hit = 1'b1;
            end
        end
    end

    assign ready_hit = |(TokenReady_i & grant_vec);
    assign tmo_hit   = (timeout_cfg_i != '0) && (tmo_q == timeout_cfg_i - TMO_W'(1));
    assign done      = ready_hit || tmo_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d      = state_q;
        slack_d      = slack_q;
        tmo_d        = tmo_q;
        ptr_d        = ptr_q;
        timeout_d    = 1'b0;
        timeout_ch_d = timeout_ch_q;
        round_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!enable_i) begin
                    slack_d = '0;
                end else if (slack_q == slack_cfg_i) begin
                    slack_d = '0;
                    if (|ch_mask_i) begin
                        ptr_d   = wrap_ch;
                        tmo_d   = '0;
                        state_d = ST_GRANT;
                    end
                end else begin
                    slack_d = slack_q + SLACK_W'(1);
                end
            end

            ST_GRANT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (done) begin
                    tmo_d = '0;
                    // Ready wins over a coincident timeout.
                    if (tmo_hit && !ready_hit) begin
                        timeout_d    = 1'b1;
                        timeout_ch_d = ptr_q;
                    end
                    if (burst_i && enable_i) begin
                        if (burst_hit) begin
                            ptr_d = burst_ch;
                        end else begin
                            ptr_d        = '0;
                            round_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        ptr_d        = nxt_ch;
                        round_done_d = nxt_wrap;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rstn) begin
            state_q      <= ST_IDLE;
            slack_q      <= '0;
            tmo_q        <= '0;
            ptr_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_ch_q <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slack_q      <= slack_d;
            tmo_q        <= tmo_d;
            ptr_q        <= ptr_d;
            timeout_q    <= timeout_d;
            timeout_ch_q <= timeout_ch_d;
            round_done_q <= round_done_d;
        end
    end

    assign TokenValid_o = grant_vec;
    assign cur_ch_o     = ptr_q;
    assign busy_o       = (state_q == ST_GRANT);
    assign timeout_o    = timeout_q;
    assign timeout_ch_o = timeout_ch_q;
    assign round_done_o = round_done_q;

endmodule

// File: tb/tb_token_round_scheduler.sv
// Scoreboard bench for token_round_scheduler: directed scenarios push expected
// grant records; a negedge monitor reconstructs grants and compares them.
module tb_token_round_scheduler;

    localparam int NUM_CH  = 17;
    localparam int CH_W    = 5;
    localparam int SLACK_W = 33;
    localparam int TMO_W   = 16;
    localparam logic [NUM_CH-1:0] ALL_CH = '1;

    logic               clk = 1'b0;
    logic               rstn;
    logic               enable_i;
    logic               burst_i;
    logic [SLACK_W-1:0] slack_cfg_i;
    logic [TMO_W-1:0]   timeout_cfg_i;
    logic [NUM_CH-1:0]  ch_mask_i;
    logic [NUM_CH-1:0]  TokenReady_i;
    logic [NUM_CH-1:0]  TokenValid_o;
    logic [CH_W-1:0]    cur_ch_o;
    logic               busy_o;
    logic               timeout_o;
    logic [CH_W-1:0]    timeout_ch_o;
    logic               round_done_o;

    token_round_scheduler #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .SLACK_W(SLACK_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable_i     (enable_i),
        .burst_i      (burst_i),
        .slack_cfg_i  (slack_cfg_i),
        .timeout_cfg_i(timeout_cfg_i),
        .ch_mask_i    (ch_mask_i),
        .TokenReady_i (TokenReady_i),
        .TokenValid_o (TokenValid_o),
        .cur_ch_o     (cur_ch_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .timeout_ch_o (timeout_ch_o),
        .round_done_o (round_done_o)
    );

    always #5 clk = ~clk;

    // gap = idle cycles before the grant (-1: don't care), len = valid cycles,
    // rd/to = round_done_o / timeout_o seen in the cycle the grant ends.
    typedef struct {
        int ch;
        int len;
        int gap;
        bit rd;
        bit to;
    } grant_t;

    grant_t exp_q[$];
    int     n_vec = 0;
    int     n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input int ch, input int len, input int gap, input bit rd, input bit to);
        grant_t g;
        g.ch  = ch;
        g.len = len;
        g.gap = gap;
        g.rd  = rd;
        g.to  = to;
        exp_q.push_back(g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable_i = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: %0d grants still expected after %0d cycles, required 0", tag, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_grant(input string tag, input int ch, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!TokenValid_o[ch] && n < budget);
        if (!TokenValid_o[ch]) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: channel %0d never granted within %0d cycles", tag, ch, budget);
        end
    endtask

    // Monitor: reconstructs each grant segment and scores it against exp_q.
    initial begin : monitor
        logic [NUM_CH-1:0] prev_v;
        logic [NUM_CH-1:0] exp_v;
        int                seg_len, seg_gap, gap_cnt, seg_cur;
        grant_t            e;
        prev_v  = '0;
        seg_len = 0;
        seg_gap = 0;
        gap_cnt = 0;
        seg_cur = 0;
        forever begin
            @(negedge clk);
            if (prev_v != '0 && TokenValid_o != prev_v) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got valid 0x%0h, required no grant", prev_v);
                end else begin
                    e     = exp_q.pop_front();
                    exp_v = NUM_CH'(1) << e.ch;
                    check("grant_valid", 64'(prev_v), 64'(exp_v));
                    check("grant_cur_ch", 64'(seg_cur), 64'(e.ch));
                    check("grant_len", 64'(seg_len), 64'(e.len));
                    if (e.gap >= 0) check("grant_gap", 64'(seg_gap), 64'(e.gap));
                    check("round_done", 64'(round_done_o), 64'(e.rd));
                    check("timeout_pulse", 64'(timeout_o), 64'(e.to));
                    if (e.to) check("timeout_ch", 64'(timeout_ch_o), 64'(e.ch));
                end
            end else if (round_done_o || timeout_o) begin
                n_vec++;
                n_bad++;
                $display("FAIL stray_pulse: got round_done=%0b timeout=%0b, required 0", round_done_o, timeout_o);
            end

            if (TokenValid_o == '0) begin
                gap_cnt = (prev_v != '0) ? 1 : gap_cnt + 1;
            end else if (TokenValid_o != prev_v) begin
                seg_len = 1;
                seg_gap = (prev_v == '0) ? gap_cnt : 0;
                seg_cur = int'(cur_ch_o);
                check("busy_in_grant", 64'(busy_o), 64'd1);
            end else begin
                seg_len++;
            end
            prev_v = TokenValid_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit any_busy;
        rstn          = 1'b0;
        enable_i      = 1'b0;
        burst_i       = 1'b0;
        slack_cfg_i   = '0;
        timeout_cfg_i = '0;
        ch_mask_i     = '0;
        TokenReady_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(TokenValid_o), 64'd0);
        check("rst_cur_ch", 64'(cur_ch_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_timeout_ch", 64'(timeout_ch_o), 64'd0);
        check("rst_round_done", 64'(round_done_o), 64'd0);
        rstn = 1'b1;

        // Full mask, single grants: 0..16 then 0, 12 cycles apart, wrap on ch16.
        do_reset();
        slack_cfg_i  = 33'd10;
        ch_mask_i    = ALL_CH;
        TokenReady_i = ALL_CH;
        for (int k = 0; k < NUM_CH; k++) exp_grant(k, 1, (k == 0) ? -1 : 11, k == NUM_CH - 1, 1'b0);
        exp_grant(0, 1, 11, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_drain("rr_full_mask", 400);
        enable_i = 1'b0;

        // Sparse mask: only ch0 and ch2 alternate.
        do_reset();
        slack_cfg_i = 33'd3;
        ch_mask_i   = 17'h00005;
        exp_grant(0, 1, -1, 1'b0, 1'b0);
        exp_grant(2, 1, 4, 1'b0, 1'b0);
        exp_grant(0, 1, 4, 1'b0, 1'b0);
        exp_grant(2, 1, 4, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_drain("sparse_mask", 100);
        enable_i = 1'b0;

        // Burst: two back-to-back sweeps separated by 6 idle cycles.
        do_reset();
        slack_cfg_i = 33'd5;
        ch_mask_i   = ALL_CH;
        burst_i     = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                exp_grant(k, 1, (k != 0) ? 0 : ((r == 0) ? -1 : 6), k == NUM_CH - 1, 1'b0);
            end
        end
        enable_i = 1'b1;
        wait_drain("burst_sweep", 200);
        enable_i = 1'b0;
        burst_i  = 1'b0;

        // Timeout on ch3 after 4 cycles, next grant ch4.
        do_reset();
        slack_cfg_i   = 33'd2;
        timeout_cfg_i = 16'd4;
        TokenReady_i  = ALL_CH & ~17'h00008;
        for (int k = 0; k < 3; k++) exp_grant(k, 1, (k == 0) ? -1 : 3, 1'b0, 1'b0);
        exp_grant(3, 4, 3, 1'b0, 1'b1);
        exp_grant(4, 1, 3, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_drain("grant_timeout", 100);
        enable_i = 1'b0;

        // Ready on the last allowed cycle beats the timeout.
        do_reset();
        for (int k = 0; k < 3; k++) exp_grant(k, 1, (k == 0) ? -1 : 3, 1'b0, 1'b0);
        exp_grant(3, 4, 3, 1'b0, 1'b0);
        exp_grant(4, 1, 3, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_grant("ready_vs_timeout", 3, 100);
        repeat (3) @(negedge clk);
        TokenReady_i[3] = 1'b1;
        @(negedge clk);
        TokenReady_i[3] = 1'b0;
        wait_drain("ready_vs_timeout", 100);
        enable_i      = 1'b0;
        timeout_cfg_i = '0;

        // Reset mid-grant on ch7: token drops, pointer restarts at ch0.
        do_reset();
        slack_cfg_i  = 33'd1;
        TokenReady_i = ALL_CH & ~17'h00080;
        for (int k = 0; k < 7; k++) exp_grant(k, 1, (k == 0) ? -1 : 2, 1'b0, 1'b0);
        exp_grant(7, 3, 2, 1'b0, 1'b0);
        exp_grant(0, 1, 2, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_grant("reset_mid_grant", 7, 100);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rst_mid_valid", 64'(TokenValid_o), 64'd0);
        check("rst_mid_cur_ch", 64'(cur_ch_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        wait_drain("reset_mid_grant", 50);
        enable_i     = 1'b0;
        TokenReady_i = ALL_CH;

        // Disable during a burst grant: grant finishes, block idles at ch3.
        do_reset();
        burst_i      = 1'b1;
        TokenReady_i = ALL_CH & ~17'h00004;
        exp_grant(0, 1, -1, 1'b0, 1'b0);
        exp_grant(1, 1, 0, 1'b0, 1'b0);
        exp_grant(2, 2, 0, 1'b0, 1'b0);
        enable_i = 1'b1;
        wait_grant("disable_in_burst", 2, 100);
        enable_i = 1'b0;
        @(negedge clk);
        TokenReady_i[2] = 1'b1;
        wait_drain("disable_in_burst", 50);
        repeat (20) @(negedge clk);
        check("disable_cur_ch", 64'(cur_ch_o), 64'd3);
        check("disable_busy", 64'(busy_o), 64'd0);
        burst_i = 1'b0;

        // Empty mask: never busy, never valid.
        do_reset();
        slack_cfg_i = 33'd2;
        ch_mask_i   = '0;
        enable_i    = 1'b1;
        any_busy    = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy_o || TokenValid_o != '0) any_busy = 1'b1;
        end
        check("mask0_busy", 64'(any_busy), 64'd0);
        enable_i = 1'b0;

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/token_round_scheduler.md
Name: token_round_scheduler

Overview:
- Parametrised successor to the single-token boot sequencer in the readout network.
- Waits a programmable slack interval, then issues a one-hot token (TokenValid_o) to readout channels in round-robin order and holds it until that channel returns TokenReady_i.
- Adds a per-channel enable mask, a grant timeout with error report, and a burst mode that sweeps a full round per slack interval.
- Sits between the readout-net channel controllers and the system control registers.

Parameters:
NUM_CH, 17, number of token channels (2..32)
CH_W, 5, channel index width, at least clog2(NUM_CH)
SLACK_W, 33, slack counter / slack_cfg_i width
TMO_W, 16, grant timeout counter / timeout_cfg_i width

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, synchronous, active-low
enable_i  input  1  scheduler enable
burst_i  input  1  0 = one grant per slack interval; 1 = full round per slack interval
slack_cfg_i  input  SLACK_W  slack interval terminal count
timeout_cfg_i  input  TMO_W  grant timeout in cycles; 0 = timeout disabled
ch_mask_i  input  NUM_CH  1 = channel participates
TokenReady_i  input  NUM_CH  per-channel grant completion
TokenValid_o  output  NUM_CH  one-hot token grant
cur_ch_o  output  CH_W  index of the channel currently granted or next to grant
busy_o  output  1  high in GRANT state
timeout_o  output  1  one-cycle pulse when a grant times out
timeout_ch_o  output  CH_W  channel that timed out, held until the next timeout
round_done_o  output  1  one-cycle pulse when the pointer wraps NUM_CH-1 -> 0

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE; slack count, timeout count and pointer = 0; all outputs 0.
- A reset asserted mid-grant drops TokenValid_o on the next edge. No completion or timeout is reported.
- All outputs are decoded from registers only.
- TokenValid_o[i] = (state==GRANT) & (ptr==i). cur_ch_o = ptr.
- Next-channel search: the first channel j with ch_mask_i[j]=1, scanning from a start index upward and wrapping at NUM_CH-1 to 0. Purely combinational; no extra cycle.
- IDLE:
  - enable_i=0: slack count is held at 0.
  - enable_i=1: slack count increments by 1 per cycle.
  - When slack count == slack_cfg_i:
    - Slack count clears.
    - If any mask bit is set: ptr <= search(ptr), state <= GRANT.
    - If the mask is all zero: stay in IDLE and restart the interval.
  - slack_cfg_i=0 gives one IDLE cycle between grants.
- GRANT:
  - Timeout count increments each cycle and is cleared on entry.
  - Completion is either of:
    - TokenReady_i[ptr]=1, or
    - timeout_cfg_i!=0 and timeout count == timeout_cfg_i-1 with no ready that cycle.
  - On timeout completion: timeout_o=1 for one cycle; timeout_ch_o <= ptr.
  - Ready and timeout in the same cycle: ready wins, no timeout pulse.
  - On completion, let nxt = ptr+1, wrapping to 0 after NUM_CH-1. round_done_o pulses if the wrap occurs, or if the burst search below passes the wrap point.
  - burst_i=0: ptr <= nxt; state <= IDLE.
  - burst_i=1:
    - If an unmasked channel exists in [nxt, NUM_CH-1] and nxt!=0: ptr <= that channel, stay in GRANT. TokenValid_o moves to the new channel on the next cycle, with no gap; timeout count clears.
    - Otherwise: ptr <= 0, round_done_o pulses, state <= IDLE.
  - enable_i=0 during GRANT: the current grant runs to completion, then the block goes to IDLE regardless of burst_i.
- ch_mask_i is sampled only at search time. Clearing the mask bit of the granted channel does not abort its grant.
- TokenReady_i bits of non-granted channels are ignored.
- burst_i, slack_cfg_i and timeout_cfg_i may change at any time. They take effect at the next comparison.
- Slack and timeout counters saturate-free: they cannot overrun because they clear at terminal count.

Test Plan:
- NUM_CH=17, slack_cfg=10, mask all 1, burst=0, ready tied high -> TokenValid_o one-hot 0,1,2,..16,0. Grants are 12 cycles apart. round_done_o pulses on completion of ch16.
- mask=17'h00005 (ch0, ch2), burst=0 -> grants alternate ch0, ch2. Channels 1 and 3-16 never see valid.
- burst=1, mask all 1, ready high, slack_cfg=5 -> 17 consecutive single-cycle grants 0..16 with no gap. Then round_done_o, then 6 IDLE cycles, then repeat.
- timeout_cfg=4, ch3 ready held low -> ch3 valid for exactly 4 cycles. timeout_o pulses once, timeout_ch_o=3, next grant is ch4.
- ch3 ready asserted on the 4th grant cycle with timeout_cfg=4 -> normal completion, no timeout_o.
- rstn=0 for one edge while ch7 is granted -> TokenValid_o=0 next cycle. cur_ch_o=0, and the next grant after the slack interval is ch0. mask=0 -> no valid ever, busy_o stays 0.
